// File: rtl/parity_serializer.sv
// parity_serializer: takes parallel words over valid/ready and sends each one
// serially, LSB first, followed by an even or odd parity bit. The frame
// format matches what parity_checker expects at the far end of the link.
module parity_serializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_TYPE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  serial_out,
  output logic                  serial_valid_out,
  output logic                  frame_start_out,
  output logic                  frame_end_out,
  output logic                  parity_out,
  output logic                  busy_out
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic ODD_PARITY = (PARITY_TYPE != 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic                  parity_reg, parity_next;
  logic                  accept;

  // A new word can be taken when idle, or while the previous parity bit is
  // on the wire so frames can run back-to-back with no gap.
  assign ready_out = en & ((state_reg == ST_IDLE) | (state_reg == ST_PARITY));
  assign accept    = ready_out & valid_in;

  // Next-state logic; with en low every register simply holds.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    if (en) begin
      case (state_reg)
        ST_IDLE, ST_PARITY: begin
          if (accept) begin
            state_next  = ST_DATA;
            cnt_next    = '0;
            shift_next  = data_in;
            parity_next = (^data_in) ^ ODD_PARITY;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt_reg == LAST_BIT) begin
            state_next = ST_PARITY;
          end else begin
            cnt_next   = cnt_reg + CNT_W'(1);
            shift_next = shift_reg >> 1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // State registers; reset aborts any frame in flight and drops a
  // simultaneous accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
    end
  end

  // Outputs are pure decodes of registered state, so each bit is stable for
  // a whole (possibly en-stretched) bit period.
  always_comb begin
    serial_out       = 1'b0;
    serial_valid_out = 1'b0;
    frame_start_out  = 1'b0;
    frame_end_out    = 1'b0;
    case (state_reg)
      ST_DATA: begin
        serial_out       = shift_reg[0];
        serial_valid_out = 1'b1;
        frame_start_out  = (cnt_reg == '0);
      end
      ST_PARITY: begin
        serial_out       = parity_reg;
        serial_valid_out = 1'b1;
        frame_end_out    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_out   = serial_valid_out;
  assign parity_out = parity_reg;

endmodule

// File: tb/tb_parity_serializer.sv
// Testbench for parity_serializer: an even-parity and an odd-parity instance
// share stimulus and are compared every cycle against a symbol-queue model.
module tb_parity_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, valid_in;
  logic [7:0] data_in;
  logic ready_e, ser_e, sv_e, fs_e, fe_e, par_e, busy_e;
  logic ready_o, ser_o, sv_o, fs_o, fe_o, par_o, busy_o;

  parity_serializer #(.DATA_WIDTH(8), .PARITY_TYPE(0)) dut_even (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_e), .serial_out(ser_e), .serial_valid_out(sv_e),
    .frame_start_out(fs_e), .frame_end_out(fe_e), .parity_out(par_e),
    .busy_out(busy_e)
  );

  parity_serializer #(.DATA_WIDTH(8), .PARITY_TYPE(1)) dut_odd (
    .clk(clk), .rst(rst), .en(en), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_o), .serial_out(ser_o), .serial_valid_out(sv_o),
    .frame_start_out(fs_o), .frame_end_out(fe_o), .parity_out(par_o),
    .busy_out(busy_o)
  );

  int checks = 0;
  int failures = 0;

  // Model: pending symbols of the frame plus the symbol currently on the wire.
  // Symbol = {is_parity_bit, is_first_bit, even-parity-domain bit value}.
  logic [2:0] sym_q[$];
  logic [2:0] cur_sym = 3'b000;
  logic       cur_valid = 1'b0;
  logic       exp_par_even = 1'b0;
  logic       exp_par_odd = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: apply inputs, check all outputs, advance the model.
  task automatic step(input logic r, input logic e, input logic v,
                      input logic [7:0] d, output logic acc);
    logic mready, p, odd_bit;
    @(negedge clk);
    rst = r; en = e; valid_in = v; data_in = d;
    #1;
    mready  = e & (sym_q.size() == 0) & (~cur_valid | cur_sym[2]);
    odd_bit = cur_sym[2] ? ~cur_sym[0] : cur_sym[0];
    check_eq("ready_even", ready_e, mready);
    check_eq("ready_odd", ready_o, mready);
    check_eq("serial_valid", sv_e, cur_valid);
    check_eq("busy", busy_e, cur_valid);
    check_eq("serial_valid_odd", sv_o, cur_valid);
    check_eq("frame_start", fs_e, cur_valid & cur_sym[1]);
    check_eq("frame_end", fe_e, cur_valid & cur_sym[2]);
    check_eq("serial_even", ser_e, cur_valid & cur_sym[0]);
    check_eq("serial_odd", ser_o, cur_valid & odd_bit);
    check_eq("parity_even", par_e, exp_par_even);
    check_eq("parity_odd", par_o, exp_par_odd);
    acc = e & v & mready & ~r;
    @(posedge clk);
    if (r) begin
      sym_q.delete();
      cur_valid    = 1'b0;
      exp_par_even = 1'b0;
      exp_par_odd  = 1'b0;
    end else if (e) begin
      if (acc) begin
        p = 1'($countones(d) % 2);
        for (int k = 0; k < 8; k++) sym_q.push_back({1'b0, (k == 0), d[k]});
        sym_q.push_back({1'b1, 1'b0, p});
        exp_par_even = p;
        exp_par_odd  = ~p;
        $display("accept data=%02h even_parity=%0d", d, p);
      end
      if (sym_q.size() > 0) begin
        cur_sym   = sym_q.pop_front();
        cur_valid = 1'b1;
      end else begin
        cur_valid = 1'b0;
      end
    end
  endtask

  // Hold valid/data until accepted; returns the number of cycles it took.
  task automatic send(input logic [7:0] d, output int n);
    logic acc;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      step(1'b0, 1'b1, 1'b1, d, acc);
      n++;
    end
    check_eq("accept_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00, acc);
  endtask

  initial begin
    logic acc;
    logic [7:0] d;
    logic e, r;
    int n, guard;

    rst = 1'b1; en = 1'b0; valid_in = 1'b0; data_in = 8'h00;
    @(posedge clk);
    @(posedge clk);

    // Reset state, then all-ones word.
    step(1'b1, 1'b1, 1'b0, 8'h00, acc);
    send(8'hFF, n);
    idle(11);

    // Mixed word: parity 1 even / 0 odd.
    send(8'b0101_0100, n);
    idle(11);

    // Back-to-back: second word accepted on the first parity cycle.
    send(8'hFF, n);
    send(8'h01, n);
    check_eq("b2b_wait_cycles", n, 9);
    idle(12);

    // en low for three cycles while bit 3 is on the wire.
    send(8'hA5, n);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h3C, acc);
    idle(10);

    // Reset at bit 5 aborts the frame; a following word goes out cleanly.
    send(8'h3C, n);
    idle(5);
    step(1'b1, 1'b1, 1'b1, 8'hC3, acc);
    idle(2);
    send(8'h5A, n);
    idle(11);

    // Reset together with an accept: the word is dropped.
    step(1'b1, 1'b1, 1'b1, 8'h77, acc);
    idle(3);

    // Randomized words with en gaps, idle gaps and occasional resets.
    for (int w = 0; w < 256; w++) begin
      d = 8'($urandom);
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        e = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 299) == 0);
        step(r, e, 1'b1, d, acc);
        guard++;
      end
      check_eq("rand_accept_timeout", acc, 1'b1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        e = ($urandom_range(0, 3) != 0);
        step(1'b0, e, 1'b0, 8'h00, acc);
      end
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_serializer.md
Name: parity_serializer

Overview:
Transmit-side companion to parity_checker. Accepts parallel data words over a valid/ready handshake and computes even or odd parity. Shifts each word out serially, LSB first, followed by one parity bit, so that the far end can rebuild the word and run it through parity_checker. Sits between a word source (FIFO/packetiser) and a 1-bit serial link.

Parameters:
DATA_WIDTH, 8, width of the parallel input word; must be >= 2.
PARITY_TYPE, 0, 0 = even parity (parity bit = XOR of data), 1 = odd parity (parity bit = ~XOR of data); same encoding as parity_checker.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
en  input  1  clock enable; when low all state, counters and outputs hold.
data_in  input  DATA_WIDTH  parallel word to transmit.
valid_in  input  1  data_in is valid.
ready_out  output  1  block can accept a word this cycle.
serial_out  output  1  serial bit stream (data bits LSB first, then parity).
serial_valid_out  output  1  serial_out carries a frame bit this cycle.
frame_start_out  output  1  high on the cycle serial_out carries data bit 0.
frame_end_out  output  1  high on the cycle serial_out carries the parity bit.
parity_out  output  1  parity bit of the word currently in flight (stable for the whole frame).
busy_out  output  1  a frame is in progress.

Behaviour:
- Reset (rst high at a clk edge, regardless of en): state=IDLE, bit counter=0, shift reg=0. All outputs 0 except ready_out, which follows its combinational equation (ready_out=en in IDLE). A frame in progress is aborted; no parity bit is sent for it.
- Accept: a transfer occurs on the rising edge where en & valid_in & ready_out are all high. data_in is captured into the shift register and parity_out is registered on that edge.
- ready_out = en & (state==IDLE | state==PARITY). This is combinational from state and en.
- State machine:
  - IDLE -> DATA on accept.
  - DATA shifts one bit per enabled cycle. The counter runs 0..DATA_WIDTH-1; at DATA_WIDTH-1 it goes to PARITY.
  - PARITY -> DATA if an accept occurs in the same cycle (back-to-back, no gap). Otherwise PARITY -> IDLE.
- Serial timing: for an accept at edge N, outputs are registered as follows.
  - Data bit k is on serial_out for the cycle after edge N+k, for k = 0..DATA_WIDTH-1.
  - The parity bit is on serial_out for the cycle after edge N+DATA_WIDTH.
  - A frame is DATA_WIDTH+1 valid cycles.
- serial_valid_out=1 and busy_out=1 in DATA and PARITY; both are 0 in IDLE. serial_out=0 in IDLE.
- frame_start_out=1 only while bit 0 is driven. frame_end_out=1 only while the parity bit is driven.
- Back-to-back: the next word's bit 0 immediately follows the previous parity bit. parity_out updates to the new word's parity on the same edge.
- en low: all registers hold, including mid-frame, and the current serial_out bit is extended. ready_out=0, so no accept is possible. Frame content is unaffected; only the timing stretches.
- Simultaneous rst and accept: rst wins and the word is dropped.
- valid_in while ready_out=0: ignored. The source must hold data/valid until accepted.
- data_in changes after accept have no effect on the frame in flight.

Test Plan:
- PARITY_TYPE=0, accept 8'hFF -> serial 1,1,1,1,1,1,1,1 then parity 0; frame_start on the first bit, frame_end on the 9th; serial_valid high for exactly 9 cycles.
- PARITY_TYPE=0, accept 8'b01010100 -> serial 0,0,1,0,1,0,1,0 then parity 1. Rerun with PARITY_TYPE=1 -> parity 0.
- Back-to-back: valid_in held high with 8'hFF then 8'h01 (even) -> 18 contiguous valid bits 1×8,0,1,0×7,1. ready_out pulses high on the first parity cycle; no IDLE gap.
- en deasserted for 3 cycles during bit 3 of 8'hA5 -> bit 3 held for 4 cycles. Bit sequence is still 1,0,1,0,0,1,0,1 then parity 0. ready_out=0 while en low.
- rst asserted at bit 5 of a frame -> next cycle all outputs 0, ready_out=1. A new word accepted afterwards transmits correctly from bit 0.
- Loopback: deserialise serial_out into parity_checker (same params) for 256 random words with random en gaps -> valid_out=1 for every frame; no data mismatch.
